// File: rtl/nvram_upload_pkg.sv
// Shared types and constants for the NVRAM upload responder.
package nvram_upload_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PAUSE_WAIT,
        FETCH,
        LATCH,
        READY
    } state_e;

    localparam logic [7:0] DEFAULT_INDEX = 8'd4;
    localparam logic [7:0] PAD_BYTE      = 8'hFF;

endpackage

// File: rtl/nvram_dirty_tracker.sv
// Snoops CPU writes into the NVRAM window; reports dirty and a quiet-period expiry.
module nvram_dirty_tracker #(
    parameter int unsigned        ADDR_W = 16,
    parameter logic [ADDR_W-1:0]  BASE   = 16'h6000,
    parameter int unsigned        LENGTH = 256,
    parameter logic [19:0]        QUIET  = 20'd800000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              clear,
    output logic              dirty,
    output logic              quiet
);

    // Window end is computed one bit wider so BASE+LENGTH never wraps.
    localparam logic [32:0] WIN_END = 33'(BASE) + 33'(LENGTH);

    logic        dirty_q, dirty_d;
    logic [19:0] cnt_q, cnt_d;
    logic        in_win;

    assign in_win = (33'(cpu_addr) >= 33'(BASE)) && (33'(cpu_addr) < WIN_END);

    always_comb begin
        dirty_d = dirty_q;
        cnt_d   = cnt_q;
        if (clear) begin
            dirty_d = 1'b0;
            cnt_d   = 20'd0;
        end else if (cpu_wr && in_win) begin
            dirty_d = 1'b1;
            cnt_d   = QUIET;
        end else if (cnt_q != 20'd0) begin
            cnt_d = cnt_q - 20'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dirty_q <= 1'b0;
            cnt_q   <= 20'd0;
        end else begin
            dirty_q <= dirty_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dirty = dirty_q;
    assign quiet = (cnt_q == 20'd0);

endmodule

// File: rtl/nvram_upload_server.sv
// Serves a window of game RAM to the HPS over ioctl upload, pausing the CPU meanwhile.
module nvram_upload_server
    import nvram_upload_pkg::*;
#(
    parameter int unsigned        ADDR_W = 16,
    parameter logic [ADDR_W-1:0]  BASE   = 16'h6000,
    parameter int unsigned        LENGTH = 256,
    parameter logic [7:0]         INDEX  = DEFAULT_INDEX,
    parameter int unsigned        RD_LAT = 1,
    parameter logic [19:0]        QUIET  = 20'd800000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_upload_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              pause_req,
    input  logic              paused,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_data,
    output logic              busy
);

    state_e      state_q, state_d;
    logic        active, active_q, start;
    logic [16:0] off_q, off_d;
    logic [1:0]  lat_q, lat_d;
    logic [7:0]  din_q, din_d;
    logic        pend_q, pend_d;
    logic [24:0] pend_addr_q, pend_addr_d;
    logic [24:0] sel_addr;
    logic [25:0] nxt_off;
    logic        nxt_oor;
    logic        clear_dirty;
    logic        dirty, quiet;

    assign active      = ioctl_upload && (ioctl_index == INDEX);
    assign start       = active && !active_q;
    assign clear_dirty = start && (state_q == IDLE);

    // Offsets past the window are clamped to LENGTH so the pad path is taken.
    assign sel_addr = ioctl_rd ? ioctl_addr : pend_addr_q;
    assign nxt_off  = 26'(sel_addr) + 26'd1;
    assign nxt_oor  = (nxt_off >= 26'(LENGTH));

    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        lat_d       = lat_q;
        din_d       = din_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;

        if (state_q != IDLE && !active) begin
            state_d = IDLE;
            pend_d  = 1'b0;
            lat_d   = 2'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = PAUSE_WAIT;
                        off_d   = 17'd0;
                        lat_d   = 2'd0;
                        pend_d  = 1'b0;
                    end
                end
                PAUSE_WAIT: begin
                    if (paused) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    if (lat_q == 2'(RD_LAT - 1)) begin
                        state_d = LATCH;
                        lat_d   = 2'd0;
                    end else begin
                        lat_d = lat_q + 2'd1;
                    end
                end
                LATCH: begin
                    din_d   = (off_q >= 17'(LENGTH)) ? PAD_BYTE : ram_data;
                    state_d = READY;
                end
                READY: begin
                    if (ioctl_rd || pend_q) begin
                        off_d   = nxt_oor ? 17'(LENGTH) : 17'(nxt_off);
                        pend_d  = 1'b0;
                        state_d = nxt_oor ? LATCH : FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase

            // One-deep pending slot; later strobes before service are dropped.
            if (ioctl_rd && !pend_q && state_q != IDLE && state_q != READY) begin
                pend_d      = 1'b1;
                pend_addr_d = ioctl_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            active_q    <= 1'b0;
            off_q       <= 17'd0;
            lat_q       <= 2'd0;
            din_q       <= PAD_BYTE;
            pend_q      <= 1'b0;
            pend_addr_q <= 25'd0;
        end else begin
            state_q     <= state_d;
            active_q    <= active;
            off_q       <= off_d;
            lat_q       <= lat_d;
            din_q       <= din_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    nvram_dirty_tracker #(
        .ADDR_W (ADDR_W),
        .BASE   (BASE),
        .LENGTH (LENGTH),
        .QUIET  (QUIET)
    ) u_dirty (
        .clk      (clk),
        .reset    (reset),
        .cpu_wr   (cpu_wr),
        .cpu_addr (cpu_addr),
        .clear    (clear_dirty),
        .dirty    (dirty),
        .quiet    (quiet)
    );

    assign ioctl_din        = din_q;
    assign busy             = (state_q != IDLE);
    assign pause_req        = busy;
    assign ram_rd           = (state_q == FETCH);
    assign ram_addr         = BASE + ADDR_W'(off_q);
    assign ioctl_upload_req = dirty && quiet && (state_q == IDLE);

endmodule
